// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency word store answering MEM-stage loads and stores,
// stalling the pipeline while an access is in flight.
module dmem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_read,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stall,
   output logic [31:0] rdata,
   output logic        rdata_valid,
   output logic        addr_err
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
   logic [1:0]  state;
   logic [3:0]  cnt;
   logic        op_rd, op_wr;
   logic [31:0] addr, wdata;
   logic [29:0] idx;
   logic        err;
   logic [31:0] mem [DEPTH_WORDS];
   assign idx = addr[31:2];
   // upper index bits must be zero: no wrap-around into the array
   assign err = (op_rd & op_wr) | (addr[1:0] != 2'b00) | (idx >= 30'(DEPTH_WORDS));
   assign stall = (state == IDLE && (req_read | req_write)) || state == BUSY;
   assign rdata_valid = state == DONE;
   assign addr_err = rdata_valid & err;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= 4'd0;
         op_rd <= 1'b0;
         op_wr <= 1'b0;
         addr  <= 32'd0;
         wdata <= 32'd0;
         rdata <= 32'd0;
         for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'd0;
      end else begin
         case (state)
            IDLE: if (req_read | req_write) begin
               op_rd <= req_read;
               op_wr <= req_write;
               addr  <= req_addr;
               wdata <= req_wdata;
               cnt   <= 4'(LATENCY - 1);
               state <= BUSY;
            end
            BUSY: if (cnt != 4'd0) cnt <= cnt - 4'd1;
            else begin
               state <= DONE;
               if (err) rdata <= 32'd0;
               else if (op_wr) mem[idx[AW-1:0]] <= wdata;
               else rdata <= mem[idx[AW-1:0]];
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed accesses with a scoreboard queue checked by a
// monitor on every completion pulse; a second LATENCY=1 instance checks short timing.
module tb_dmem_responder;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        req_read = 1'b0, req_write = 1'b0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic        stall, rdata_valid, addr_err;
   logic [31:0] rdata;
   logic        r1_read = 1'b0, r1_write = 1'b0;
   logic [31:0] r1_addr = '0, r1_wdata = '0;
   logic        stall1, valid1, err1;
   logic [31:0] rdata1;
   int n_cmp = 0, n_bad = 0;
   typedef struct { logic [31:0] rd; logic err; logic ck; } exp_t;
   exp_t q[$];

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_WORDS(256), .LATENCY(3)) dut (
      .clk(clk), .rst_n(rst_n), .req_read(req_read), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall), .rdata(rdata),
      .rdata_valid(rdata_valid), .addr_err(addr_err));

   dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .req_read(r1_read), .req_write(r1_write),
      .req_addr(r1_addr), .req_wdata(r1_wdata), .stall(stall1), .rdata(rdata1),
      .rdata_valid(valid1), .addr_err(err1));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rdata_valid) begin
         if (q.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
         else begin
            exp_t e;
            e = q.pop_front();
            chk("addr_err", 32'(addr_err), 32'(e.err));
            if (e.ck) chk("rdata", rdata, e.rd);
         end
      end else if (addr_err) chk("err_without_valid", 32'd1, 32'd0);
   end

   // holds the request through DONE, then drops it one edge later
   task automatic acc(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd, input logic exp_err, input logic ck);
      int n = 0;
      q.push_back('{exp_rd, exp_err, ck});
      req_read = rd; req_write = wr; req_addr = a; req_wdata = d;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!stall) break;
         n++;
      end
      chk("stall_cycles", 32'(n), 32'd4);
      @(posedge clk); #1;
      req_read = 1'b0; req_write = 1'b0;
   endtask

   task automatic acc1(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
      int n = 0;
      r1_read = rd; r1_write = wr; r1_addr = a; r1_wdata = d;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!stall1) break;
         n++;
      end
      chk("lat1_stall_cycles", 32'(n), 32'd2);
      chk("lat1_valid", 32'(valid1), 32'd1);
      @(posedge clk); #1;
      r1_read = 1'b0; r1_write = 1'b0;
   endtask

   initial begin
      #12;
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_valid", 32'(rdata_valid), 32'd0);
      chk("rst_err", 32'(addr_err), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      acc(1, 0, 32'h10, 32'h0, 32'h0, 0, 1);
      acc(0, 1, 32'h10, 32'hAAAA5555, 32'h0, 0, 1);
      acc(1, 0, 32'h10, 32'h0, 32'hAAAA5555, 0, 1);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst_rdata", rdata, 32'd0);
      chk("async_rst_stall", 32'(stall), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      acc(1, 0, 32'h10, 32'h0, 32'h0, 0, 1);
      acc(0, 1, 32'h40, 32'hDEADBEEF, 32'h0, 0, 1);
      acc(1, 0, 32'h40, 32'h0, 32'hDEADBEEF, 0, 1);
      acc(0, 1, 32'h44, 32'h0BADF00D, 32'hDEADBEEF, 0, 1);
      repeat (8) @(posedge clk);
      #1;
      chk("idle_queue_empty", 32'(q.size()), 32'd0);
      chk("idle_stall", 32'(stall), 32'd0);
      acc(1, 0, 32'h42, 32'h0, 32'h0, 1, 1);
      acc(0, 1, 32'h0, 32'h11111111, 32'h0, 0, 1);
      acc(0, 1, 32'h400, 32'h22222222, 32'h0, 1, 0);
      acc(1, 0, 32'h0, 32'h0, 32'h11111111, 0, 1);
      acc(1, 1, 32'h0, 32'h33333333, 32'h0, 1, 1);
      acc(1, 0, 32'h0, 32'h0, 32'h11111111, 0, 1);
      acc(1, 0, 32'h44, 32'h0, 32'h0BADF00D, 0, 1);
      acc(1, 0, 32'hFFFFFFFC, 32'h0, 32'h0, 1, 1);
      acc(1, 0, 32'h3FC, 32'h0, 32'h0, 0, 1);
      // store aborted by reset during its second BUSY cycle
      req_write = 1'b1; req_addr = 32'h80; req_wdata = 32'h12345678;
      @(posedge clk); @(posedge clk); #2;
      rst_n = 1'b0; req_write = 1'b0;
      #1;
      chk("abort_stall", 32'(stall), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      acc(1, 0, 32'h80, 32'h0, 32'h0, 0, 1);
      acc(1, 0, 32'h40, 32'h0, 32'h0, 0, 1);
      acc1(0, 1, 32'h8, 32'h55);
      acc1(1, 0, 32'h8, 32'h0);
      chk("lat1_rdata", rdata1, 32'h55);
      repeat (6) @(posedge clk);
      #1;
      chk("final_queue_empty", 32'(q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
